// File: rtl/param_engine.sv
// Escape-time iteration engine: z <= z^2 + c in signed fixed point.
// One job per latch; result {x, y, itr} handed back via a req/ack handshake.
module param_engine #(
    parameter int              DATA_W         = 32,
    parameter int              FRAC_W         = 24,
    parameter int              X_W            = 10,
    parameter int              Y_W            = 9,
    parameter int              ITR_W          = 16,
    parameter int              OUT_ITR_W      = 8,
    parameter int              MAX_ITERATIONS = 255,
    parameter logic [DATA_W-1:0] ESC_THRESH   = 32'h0400_0000,
    parameter int              ADDR_W         = 3
) (
    input  logic                                  Engine_CLK,
    input  logic                                  eRST_n,
    input  logic [ADDR_W-1:0]                     my_addr,
    input  logic [ADDR_W-1:0]                     engine_addr,
    input  logic [X_W+Y_W+2*DATA_W+ITR_W-1:0]     in_word,
    input  logic                                  latch_en,
    input  logic                                  req_ack,
    input  logic                                  abort,
    output logic [X_W+Y_W+OUT_ITR_W-1:0]          out_word,
    output logic                                  available,
    output logic                                  service_req
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ITR_W-1:0] OUT_MAX = ITR_W'({OUT_ITR_W{1'b1}});

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        CHK  = 3'd2,
        ADD  = 3'd3,
        REQ  = 3'd4,
        REL  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [X_W-1:0]           x_q, x_d;
    logic [Y_W-1:0]           y_q, y_d;
    logic signed [DATA_W-1:0] cre_q, cre_d;
    logic signed [DATA_W-1:0] cim_q, cim_d;
    logic [ITR_W-1:0]         limit_q, limit_d;
    logic [ITR_W-1:0]         cnt_q, cnt_d;
    logic signed [DATA_W-1:0] zr_q, zr_d;
    logic signed [DATA_W-1:0] zi_q, zi_d;
    logic signed [DATA_W-1:0] prr_q, prr_d;
    logic signed [DATA_W-1:0] pii_q, pii_d;
    logic signed [DATA_W-1:0] pri_q, pri_d;

    // Unpacked job fields
    logic [X_W-1:0]    in_x;
    logic [Y_W-1:0]    in_y;
    logic [DATA_W-1:0] in_cre;
    logic [DATA_W-1:0] in_cim;
    logic [ITR_W-1:0]  in_itr;

    assign {in_x, in_y, in_cre, in_cim, in_itr} = in_word;

    // Full-width signed products, rescaled by the fraction width
    logic signed [PROD_W-1:0] zr_x, zi_x;
    logic signed [PROD_W-1:0] m_rr, m_ii, m_ri;
    logic signed [PROD_W-1:0] s_rr, s_ii, s_ri;

    assign zr_x = PROD_W'(zr_q);
    assign zi_x = PROD_W'(zi_q);
    assign m_rr = zr_x * zr_x;
    assign m_ii = zi_x * zi_x;
    assign m_ri = zr_x * zi_x;
    assign s_rr = m_rr >>> FRAC_W;
    assign s_ii = m_ii >>> FRAC_W;
    assign s_ri = m_ri >>> FRAC_W;

    // |z|^2 with one guard bit so the sum cannot wrap
    logic signed [DATA_W:0] mag;
    logic                   escaped;

    assign mag     = $signed({prr_q[DATA_W-1], prr_q})
                   + $signed({pii_q[DATA_W-1], pii_q});
    assign escaped = mag > $signed({1'b0, ESC_THRESH});

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cre_d   = cre_q;
        cim_d   = cim_q;
        limit_d = limit_q;
        cnt_d   = cnt_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        prr_d   = prr_q;
        pii_d   = pii_q;
        pri_d   = pri_q;
        case (state_q)
            IDLE: begin
                zr_d  = '0;
                zi_d  = '0;
                cnt_d = '0;
                if (latch_en && (engine_addr == my_addr)) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    cre_d   = $signed(in_cre);
                    cim_d   = $signed(in_cim);
                    limit_d = (in_itr == '0) ? ITR_W'(MAX_ITERATIONS)
                                             : in_itr;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    prr_d   = s_rr[DATA_W-1:0];
                    pii_d   = s_ii[DATA_W-1:0];
                    pri_d   = s_ri[DATA_W-1:0];
                    state_d = CHK;
                end
            end
            CHK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (escaped) begin
                    state_d = REQ;
                end else if (cnt_q == limit_q) begin
                    state_d = REQ;
                end else begin
                    state_d = ADD;
                end
            end
            ADD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    zr_d    = prr_q - pii_q + cre_q;
                    zi_d    = (pri_q <<< 1) + cim_q;
                    cnt_d   = cnt_q + ITR_W'(1);
                    state_d = MUL;
                end
            end
            REQ: begin
                if (req_ack) begin
                    state_d = REL;
                end
            end
            REL: begin
                if (!(req_ack || latch_en)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Engine_CLK or negedge eRST_n) begin
        if (!eRST_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cre_q   <= '0;
            cim_q   <= '0;
            limit_q <= '0;
            cnt_q   <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            prr_q   <= '0;
            pii_q   <= '0;
            pri_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cre_q   <= cre_d;
            cim_q   <= cim_d;
            limit_q <= limit_d;
            cnt_q   <= cnt_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            prr_q   <= prr_d;
            pii_q   <= pii_d;
            pri_q   <= pri_d;
        end
    end

    // Reported count saturates at the output width
    logic [OUT_ITR_W-1:0] itr_sat;

    assign itr_sat = (cnt_q > OUT_MAX) ? '1 : cnt_q[OUT_ITR_W-1:0];

    assign available   = (state_q == IDLE);
    assign service_req = (state_q == REQ);

    // Shared result bus: drive only while the acknowledged result is held
    assign out_word = (req_ack && ((state_q == REQ) || (state_q == REL)))
                    ? {x_q, y_q, itr_sat}
                    : 'z;

endmodule
